// File: rtl/key_loader_pkg.sv
// Shared types and default constants for the serial key loader.
// Default forbidden patterns describe key settings that close a loop in the locked netlist.
package key_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck,
    StLock
  } state_e;

  localparam int unsigned KeyWDefault = 4;
  localparam int unsigned FailW       = 4;

  localparam logic [3:0] SafeKeyDefault   = 4'b0000;
  localparam logic [3:0] LoopMask0Default = 4'b1000;
  localparam logic [3:0] LoopVal0Default  = 4'b1000;
  localparam logic [3:0] LoopMask1Default = 4'b1001;
  localparam logic [3:0] LoopVal1Default  = 4'b0001;

  // Counter must reach KEY_W+1 (every accepted bit increments it, parity included).
  function automatic int unsigned cnt_width(input int unsigned key_w);
    return $clog2(key_w + 2);
  endfunction

  localparam int unsigned CntWDefault = cnt_width(KeyWDefault);

endpackage

// File: rtl/key_check.sv
// Combinational key screen: even-parity check plus forbidden loop-pattern match.
module key_check
  import key_loader_pkg::*;
#(
  parameter int unsigned          KEY_W      = KeyWDefault,
  parameter logic [KEY_W-1:0]     LOOP_MASK0 = LoopMask0Default,
  parameter logic [KEY_W-1:0]     LOOP_VAL0  = LoopVal0Default,
  parameter logic [KEY_W-1:0]     LOOP_MASK1 = LoopMask1Default,
  parameter logic [KEY_W-1:0]     LOOP_VAL1  = LoopVal1Default
) (
  input  logic [KEY_W-1:0] key,
  input  logic             parity,
  output logic             parity_ok,
  output logic             loop
);

  always_comb begin
    parity_ok = ((^key) == parity);
    loop      = ((key & LOOP_MASK0) == LOOP_VAL0) || ((key & LOOP_MASK1) == LOOP_VAL1);
  end

endmodule

// File: rtl/key_loader.sv
// Serial key provisioning: shifts in a parity-protected key frame, screens it,
// and commits only loop-free keys to the locked netlist; locks out after repeated rejects.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int unsigned      KEY_W      = KeyWDefault,
  parameter logic [KEY_W-1:0] SAFE_KEY   = SafeKeyDefault,
  parameter logic [KEY_W-1:0] LOOP_MASK0 = LoopMask0Default,
  parameter logic [KEY_W-1:0] LOOP_VAL0  = LoopVal0Default,
  parameter logic [KEY_W-1:0] LOOP_MASK1 = LoopMask1Default,
  parameter logic [KEY_W-1:0] LOOP_VAL1  = LoopVal1Default,
  parameter int unsigned      MAX_FAIL   = 3
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_vld,
  output logic             err_parity,
  output logic             err_loop,
  output logic             lockout,
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(KEY_W);

  state_e           state_q, state_d;
  logic [KEY_W:0]   shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [FailW-1:0] fail_q, fail_d, fail_inc;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_vld_q, key_vld_d;
  logic             err_par_q, err_par_d;
  logic             err_loop_q, err_loop_d;
  logic             parity_ok, loop;

  // Parity bit lands in the MSB after KEY_W+1 LSB-first shifts.
  key_check #(
    .KEY_W      (KEY_W),
    .LOOP_MASK0 (LOOP_MASK0),
    .LOOP_VAL0  (LOOP_VAL0),
    .LOOP_MASK1 (LOOP_MASK1),
    .LOOP_VAL1  (LOOP_VAL1)
  ) u_key_check (
    .key       (shreg_q[KEY_W-1:0]),
    .parity    (shreg_q[KEY_W]),
    .parity_ok (parity_ok),
    .loop      (loop)
  );

  always_comb begin
    fail_inc = (fail_q == '1) ? fail_q : fail_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    key_d      = key_q;
    key_vld_d  = key_vld_q;
    err_par_d  = 1'b0;
    err_loop_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (sdi_valid) begin
          shreg_d = {sdi, shreg_q[KEY_W:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntW'(KEY_W)) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (!parity_ok || loop) begin
          err_par_d  = !parity_ok;
          err_loop_d = parity_ok;
          fail_d     = fail_inc;
          if (fail_inc >= FailW'(MAX_FAIL)) begin
            state_d   = StLock;
            key_d     = SAFE_KEY;
            key_vld_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          state_d   = StIdle;
          key_d     = shreg_q[KEY_W-1:0];
          key_vld_d = 1'b1;
          fail_d    = '0;
        end
      end
      StLock: begin
        key_d     = SAFE_KEY;
        key_vld_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      fail_q     <= '0;
      key_q      <= SAFE_KEY;
      key_vld_q  <= 1'b0;
      err_par_q  <= 1'b0;
      err_loop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      key_q      <= key_d;
      key_vld_q  <= key_vld_d;
      err_par_q  <= err_par_d;
      err_loop_q <= err_loop_d;
    end
  end

  always_comb begin
    sdi_ready  = (state_q == StShift);
    busy       = (state_q == StShift) || (state_q == StCheck);
    lockout    = (state_q == StLock);
    keyinput   = key_q;
    key_vld    = key_vld_q;
    err_parity = err_par_q;
    err_loop   = err_loop_q;
  end

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: table of frames with a result scoreboard,
// plus hand sequences for lockout and mid-frame reset.
module tb_key_loader;
  import key_loader_pkg::*;

  logic       CK = 1'b0;
  logic       RST;
  logic       start, sdi, sdi_valid;
  logic       sdi_ready, key_vld, err_parity, err_loop, lockout, busy;
  logic [3:0] keyinput;

  logic [3:0] chk_key;
  logic       chk_par, chk_pok, chk_loop;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] key;
    logic       par;
    logic       noisy;
    logic       pok;
    logic       loop;
  } vec_t;

  typedef struct packed {
    logic       ep;
    logic       el;
    logic [3:0] key;
    logic       vld;
    logic       lock;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  logic [3:0] exp_key;
  logic       exp_vld;

  key_loader dut (
    .CK         (CK),
    .RST        (RST),
    .start      (start),
    .sdi        (sdi),
    .sdi_valid  (sdi_valid),
    .sdi_ready  (sdi_ready),
    .keyinput   (keyinput),
    .key_vld    (key_vld),
    .err_parity (err_parity),
    .err_loop   (err_loop),
    .lockout    (lockout),
    .busy       (busy)
  );

  key_check u_model (
    .key       (chk_key),
    .parity    (chk_par),
    .parity_ok (chk_pok),
    .loop      (chk_loop)
  );

  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Drives one complete frame; the expected outcome is queued up front and
  // popped once the CHECK edge has passed.
  task automatic send_frame(input logic [3:0] key, input logic par, input logic noisy,
                            input exp_t e);
    logic [4:0] bits;
    exp_t       got;
    bits = {par, key};
    sb.push_back(e);
    if (noisy) begin
      sdi_valid = 1'b1;
      sdi       = 1'b1;
      tick();
    end
    sdi_valid = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    if (!e.lock || !lockout) chk("ready_in_shift", 32'(sdi_ready), 32'(!lockout));
    for (int i = 0; i < 5; i++) begin
      if (noisy && (i % 2 == 1)) begin
        sdi_valid = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_in_gap", 32'(busy), 32'(!lockout));
      end
      sdi_valid = 1'b1;
      sdi       = bits[i];
      tick();
    end
    sdi_valid = 1'b0;
    sdi       = 1'b0;
    tick();
    got = sb.pop_front();
    chk("err_parity", 32'(err_parity), 32'(got.ep));
    chk("err_loop", 32'(err_loop), 32'(got.el));
    chk("keyinput", 32'(keyinput), 32'(got.key));
    chk("key_vld", 32'(key_vld), 32'(got.vld));
    chk("lockout", 32'(lockout), 32'(got.lock));
    tick();
    chk("err_flags_cleared", 32'({err_parity, err_loop}), 32'(0));
  endtask

  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.ep   = !v.pok;
    e.el   = v.pok && v.loop;
    if (v.pok && !v.loop) begin
      exp_key = v.key;
      exp_vld = 1'b1;
    end
    e.key  = exp_key;
    e.vld  = exp_vld;
    e.lock = 1'b0;
    return e;
  endfunction

  initial begin
    vecs[0] = '{key: 4'b0001, par: 1'b1, noisy: 1'b0, pok: 1'b1, loop: 1'b1};
    vecs[1] = '{key: 4'b0110, par: 1'b0, noisy: 1'b0, pok: 1'b1, loop: 1'b0};
    vecs[2] = '{key: 4'b0110, par: 1'b1, noisy: 1'b1, pok: 1'b0, loop: 1'b0};
    vecs[3] = '{key: 4'b0100, par: 1'b1, noisy: 1'b0, pok: 1'b1, loop: 1'b0};
    vecs[4] = '{key: 4'b1111, par: 1'b0, noisy: 1'b1, pok: 1'b1, loop: 1'b1};
    vecs[5] = '{key: 4'b0010, par: 1'b1, noisy: 1'b0, pok: 1'b1, loop: 1'b0};
    vecs[6] = '{key: 4'b0000, par: 1'b0, noisy: 1'b1, pok: 1'b1, loop: 1'b0};
    vecs[7] = '{key: 4'b1010, par: 1'b1, noisy: 1'b0, pok: 1'b0, loop: 1'b1};
    vecs[8] = '{key: 4'b0100, par: 1'b1, noisy: 1'b1, pok: 1'b1, loop: 1'b0};

    start = 1'b0; sdi = 1'b0; sdi_valid = 1'b0;
    chk_key = '0; chk_par = 1'b0;
    exp_key = 4'b0000;
    exp_vld = 1'b0;
    do_reset();

    chk("reset_keyinput", 32'(keyinput), 32'(4'b0000));
    chk("reset_key_vld", 32'(key_vld), 32'(0));
    chk("reset_flags", 32'({err_parity, err_loop, lockout}), 32'(0));
    chk("reset_busy_ready", 32'({busy, sdi_ready}), 32'(0));

    foreach (vecs[i]) begin
      chk_key = vecs[i].key;
      chk_par = vecs[i].par;
      #1;
      chk("model_parity_ok", 32'(chk_pok), 32'(vecs[i].pok));
      chk("model_loop", 32'(chk_loop), 32'(vecs[i].loop));
      send_frame(vecs[i].key, vecs[i].par, vecs[i].noisy, model(vecs[i]));
    end

    // Lockout: commit a key, then three consecutive rejects.
    do_reset();
    send_frame(4'b0110, 1'b0, 1'b0, '{ep: 1'b0, el: 1'b0, key: 4'b0110, vld: 1'b1, lock: 1'b0});
    send_frame(4'b0110, 1'b1, 1'b0, '{ep: 1'b1, el: 1'b0, key: 4'b0110, vld: 1'b1, lock: 1'b0});
    send_frame(4'b1000, 1'b1, 1'b0, '{ep: 1'b0, el: 1'b1, key: 4'b0110, vld: 1'b1, lock: 1'b0});
    send_frame(4'b0110, 1'b1, 1'b0, '{ep: 1'b1, el: 1'b0, key: 4'b0000, vld: 1'b0, lock: 1'b1});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("lock_sticky", 32'(lockout), 32'(1));
    chk("lock_ready", 32'(sdi_ready), 32'(0));
    chk("lock_busy", 32'(busy), 32'(0));
    chk("lock_keyinput", 32'(keyinput), 32'(4'b0000));
    do_reset();
    chk("lock_cleared", 32'(lockout), 32'(0));
    chk("lock_reset_busy", 32'(busy), 32'(0));

    // Reset two bits into a frame: abort with no commit, counters cleared.
    send_frame(4'b0010, 1'b1, 1'b0, '{ep: 1'b0, el: 1'b0, key: 4'b0010, vld: 1'b1, lock: 1'b0});
    start = 1'b1;
    tick();
    start     = 1'b0;
    sdi_valid = 1'b1;
    sdi       = 1'b0;
    tick();
    sdi = 1'b1;
    tick();
    sdi_valid = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'(1));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_keyinput", 32'(keyinput), 32'(4'b0000));
    chk("abort_key_vld", 32'(key_vld), 32'(0));
    chk("abort_idle", 32'({busy, sdi_ready}), 32'(0));
    tick();
    chk("abort_no_commit", 32'({keyinput, key_vld}), 32'(0));
    send_frame(4'b0100, 1'b1, 1'b0, '{ep: 1'b0, el: 1'b0, key: 4'b0100, vld: 1'b1, lock: 1'b0});

    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
